// File: rtl/examp2_and_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin AND arbiter.
package and_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int STAT_W             = 16;

  // Requester index width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/examp2_and_arbiter_rr_grant.sv
// Round-robin grant: one-hot pick of the first valid requester at or above rr_ptr.
module rr_grant
  import and_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = id_w(DEFAULT_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               load,
  output logic [NUM_REQ-1:0] grant
);

  logic          found;
  int            sum;
  logic [ID_W-1:0] idx;

  // Walk the requesters from rr_ptr upward, wrapping past NUM_REQ-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (load && !found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/examp2_and_arbiter.sv
// Shares one registered bitwise-AND stage among NUM_REQ round-robin requesters.
// Defining AND_ARB_STATS_EN adds the saturating stat_grant_cnt output.
module examp2_and_arbiter
  import and_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  localparam int ID_W      = id_w(NUM_REQ)
) (
  input  logic                          system_clock,
  input  logic                          system_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]               out_id
`ifdef AND_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]             stat_grant_cnt
`endif
);

  logic                  load;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       gnt_idx;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic                  any_grant;

  assign load      = ~out_valid | out_ready;
  assign req_ready = grant;
  assign any_grant = |grant;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .load      (load),
    .grant     (grant)
  );

  // Operand mux is steered by the grant only, so data never feeds back into arbitration.
  always_comb begin
    gnt_idx = '0;
    a_sel   = '0;
    b_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = ID_W'(i);
        a_sel   = req_data_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel   = req_data_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge system_clock or negedge system_rst_n) begin
    if (!system_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (any_grant) begin
      out_valid <= 1'b1;
      out_data  <= a_sel & b_sel;
      out_id    <= gnt_idx;
      rr_ptr    <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef AND_ARB_STATS_EN
  always_ff @(posedge system_clock or negedge system_rst_n) begin
    if (!system_rst_n) begin
      stat_grant_cnt <= '0;
    end else if (any_grant && (stat_grant_cnt != {STAT_W{1'b1}})) begin
      stat_grant_cnt <= stat_grant_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_examp2_and_arbiter.sv
// Self-checking bench for examp2_and_arbiter: vector table, corner sequences, scoreboard.
module tb_examp2_and_arbiter;

  typedef struct {
    logic [3:0] rv;
    logic       ordy;
    logic [3:0] exp_ready;
  } vec_t;

  logic        system_clock = 1'b0;
  logic        system_rst_n = 1'b0;
  logic [3:0]  req_valid    = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_data_a   = '0;
  logic [31:0] req_data_b   = '0;
  logic        out_valid;
  logic        out_ready    = 1'b0;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
`ifdef AND_ARB_STATS_EN
  logic [15:0] stat_grant_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int grant_total = 0;
  logic [1:0] model_rr = '0;
  logic [9:0] sb[$];
  vec_t vecs[20];

  localparam logic [31:0] A_FIX = 32'hC3_0F_AA_F0;
  localparam logic [31:0] B_FIX = 32'hFF_5A_66_3C;

  examp2_and_arbiter dut (
    .system_clock (system_clock),
    .system_rst_n (system_rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data_a   (req_data_a),
    .req_data_b   (req_data_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_id       (out_id)
`ifdef AND_ARB_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt)
`endif
  );

  always #5 system_clock = ~system_clock;

  function automatic logic [3:0] model_grant(input logic [3:0] rv, input logic ld,
                                             input logic [1:0] ptr);
    logic [3:0] g;
    logic [1:0] idx;
    g = '0;
    if (ld) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr + 2'(k);
        if (g == '0 && rv[idx]) g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic checkOutput(input logic [3:0] exp_ready, input string name);
    logic [1:0] idx;
    logic [7:0] a_v;
    logic [7:0] b_v;
    checks++;
    if (req_ready !== exp_ready) begin
      failures++;
      $display("[TB] FAIL %s req_ready: got %b want %b", name, req_ready, exp_ready);
    end
    checks++;
    if (out_valid !== (sb.size() != 0)) begin
      failures++;
      $display("[TB] FAIL %s out_valid: got %b want %b", name, out_valid, sb.size() != 0);
    end
    if (sb.size() != 0) begin
      checks++;
      if ({out_id, out_data} !== sb[0]) begin
        failures++;
        $display("[TB] FAIL %s result: got id=%0d data=%h want id=%0d data=%h",
                 name, out_id, out_data, sb[0][9:8], sb[0][7:0]);
      end
      if (out_ready) void'(sb.pop_front());
    end
    if (exp_ready != '0) begin
      idx = '0;
      for (int i = 0; i < 4; i++) if (exp_ready[i]) idx = 2'(i);
      a_v = req_data_a[idx*8 +: 8];
      b_v = req_data_b[idx*8 +: 8];
      sb.push_back({idx, a_v & b_v});
      model_rr = idx + 2'd1;
      grant_total++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rv, input logic ordy, input logic [31:0] a_v,
                               input logic [31:0] b_v, input logic [3:0] exp_ready,
                               input string name);
    @(posedge system_clock);
    #1;
    req_valid  = rv;
    out_ready  = ordy;
    req_data_a = a_v;
    req_data_b = b_v;
    @(negedge system_clock);
    checkOutput(exp_ready, name);
  endtask

  initial begin
    logic [3:0]  rv;
    logic        ordy;
    logic [31:0] a_r;
    logic [31:0] b_r;

    // Hand-derived table; rr_ptr tracked in the trailing notes.
    vecs[0]  = '{4'b0001, 1'b1, 4'b0001};  // single request, rr->1
    vecs[1]  = '{4'b1000, 1'b1, 4'b1000};  // rr->0
    vecs[2]  = '{4'b1111, 1'b1, 4'b0001};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0010};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0100};
    vecs[5]  = '{4'b1111, 1'b1, 4'b1000};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0001};  // rr->1
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000};  // backpressure hold
    vecs[8]  = '{4'b1111, 1'b0, 4'b0000};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0010};  // drain and reload same cycle, rr->2
    vecs[10] = '{4'b0000, 1'b1, 4'b0000};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000};
    vecs[12] = '{4'b0100, 1'b1, 4'b0100};  // rr->3
    vecs[13] = '{4'b1001, 1'b1, 4'b1000};  // wrap: 3 first
    vecs[14] = '{4'b1001, 1'b1, 4'b0001};  // then 0
    vecs[15] = '{4'b0000, 1'b1, 4'b0000};
    vecs[16] = '{4'b0010, 1'b0, 4'b0010};  // empty stage loads even with out_ready=0
    vecs[17] = '{4'b0110, 1'b0, 4'b0000};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000};  // requester 2 withdrew, never granted
    vecs[19] = '{4'b0000, 1'b1, 4'b0000};

    #12;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0 || req_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_state: got v=%b d=%h id=%0d rdy=%b want 0/00/0/0000",
               out_valid, out_data, out_id, req_ready);
    end
    #3 system_rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      applyStimulus(vecs[i].rv, vecs[i].ordy, A_FIX, B_FIX, vecs[i].exp_ready, $sformatf("vec%0d", i));

    // Load a result (rr=2 so search 2,3,0 picks 0), then reset while it is held.
    applyStimulus(4'b0001, 1'b0, A_FIX, B_FIX, 4'b0001, "pre_reset");
    #2 system_rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: got v=%b d=%h id=%0d want 0/00/0", out_valid, out_data, out_id);
    end
    sb.delete();
    model_rr = '0;
    req_valid = '0;
    #4 system_rst_n = 1'b1;
    applyStimulus(4'b1100, 1'b1, A_FIX, B_FIX, 4'b0100, "post_reset_first");
    applyStimulus(4'b0000, 1'b1, A_FIX, B_FIX, 4'b0000, "post_reset_drain");

    // Random traffic checked against the bench's own arbitration model.
    for (int i = 0; i < 200; i++) begin
      rv   = 4'($urandom_range(0, 15));
      ordy = 1'($urandom_range(0, 1));
      a_r  = $urandom;
      b_r  = $urandom;
      applyStimulus(rv, ordy, a_r, b_r, model_grant(rv, (sb.size() == 0) || ordy, model_rr),
                    $sformatf("rand%0d", i));
    end
    applyStimulus(4'b0000, 1'b1, A_FIX, B_FIX, 4'b0000, "final_drain");

`ifdef AND_ARB_STATS_EN
    checks++;
    if (stat_grant_cnt !== 16'(grant_total)) begin
      failures++;
      $display("[TB] FAIL stat_count: got %0d want %0d", stat_grant_cnt, grant_total);
    end
    @(posedge system_clock);
    #1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    repeat (70000) @(posedge system_clock);
    #1;
    checks++;
    if (stat_grant_cnt !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL stat_saturate: got %h want ffff", stat_grant_cnt);
    end
    repeat (5) @(posedge system_clock);
    #1;
    checks++;
    if (stat_grant_cnt !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL stat_hold: got %h want ffff", stat_grant_cnt);
    end
    req_valid = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
